// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and funct3 encodings for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic is_half(input logic we, input logic [2:0] funct3);
        return we ? (funct3 == SH) : (funct3 == LH || funct3 == LHU);
    endfunction

    function automatic logic is_word(input logic [2:0] funct3);
        return funct3 == LW;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - load extraction/extension and store byte-lane generation
// Behaviour on misaligned halfword/word access depends on DMEM_MISALIGN_TRAP_EN.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           we,
    input  logic [2:0]     funct3,
    input  logic [1:0]     addr_lo,
    input  logic [N-1:0]   wdata,
    input  logic [N-1:0]   rword,
    output logic [N-1:0]   rdata,
    output logic [N/8-1:0] wbe,
    output logic [N-1:0]   wdata_rep
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic           misaligned
`endif
);

    localparam int NB = N / 8;

    logic       half_acc;
    logic       word_acc;
    logic [1:0] off;
    logic [7:0] byte_v;
    logic [15:0] half_v;

    always_comb begin
        half_acc = is_half(we, funct3);
        word_acc = is_word(funct3);
        off      = addr_lo;
`ifndef DMEM_MISALIGN_TRAP_EN
        // Without trapping, wider accesses silently drop the low offset bits.
        if (half_acc) off = {addr_lo[1], 1'b0};
        if (word_acc) off = 2'b00;
`endif
        byte_v    = rword[{off, 3'b000} +: 8];
        half_v    = rword[{off[1], 4'b0000} +: 16];
        rdata     = '0;
        wbe       = '0;
        wdata_rep = '0;
        if (we) begin
            case (funct3)
                SB: begin
                    wbe       = NB'(1) << off;
                    wdata_rep = {NB{wdata[7:0]}};
                end
                SH: begin
                    wbe       = NB'(3) << off;
                    wdata_rep = {(N/16){wdata[15:0]}};
                end
                SW: begin
                    wbe       = '1;
                    wdata_rep = wdata;
                end
                default: ;
            endcase
        end else begin
            case (funct3)
                LB:      rdata = {{(N-8){byte_v[7]}}, byte_v};
                LH:      rdata = {{(N-16){half_v[15]}}, half_v};
                LW:      rdata = rword;
                LBU:     rdata = {{(N-8){1'b0}}, byte_v};
                LHU:     rdata = {{(N-16){1'b0}}, half_v};
                default: rdata = '0;
            endcase
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = (half_acc && addr_lo[0]) || (word_acc && addr_lo != 2'b00);
        if (misaligned) begin
            rdata = '0;
            wbe   = '0;
        end
`endif
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with wait states
// Optional misalignment trap and o_misaligned port: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N           = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic         i_clk,
    input  logic         i_arst,
    input  logic         i_req,
    input  logic         i_we,
    input  logic [2:0]   i_funct3,
    input  logic [N-1:0] i_addr,
    input  logic [N-1:0] i_wdata,
    output logic         o_ready,
    output logic         o_stall,
    output logic         o_rsp_valid,
    output logic [N-1:0] o_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic         o_misaligned
`endif
);

    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam int         NB = N / 8;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [AW+1:0]   addr_q;
    logic [N-1:0]    wdata_q;

    logic [N-1:0]    mem [DEPTH_WORDS];

    logic            commit;
    logic            acc_we;
    logic [2:0]      acc_f3;
    logic [AW+1:0]   acc_addr;
    logic [N-1:0]    acc_wdata;
    logic [AW-1:0]   acc_idx;
    logic [N-1:0]    rword;
    logic [N-1:0]    rdata_ext;
    logic [NB-1:0]   wbe;
    logic [N-1:0]    wdata_rep;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^i_addr[N-1:AW+2];

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req) state_d = (WS != 3'd0) ? WAIT : RESP;
            WAIT:    if (cnt_q == 3'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready     = (state_q == IDLE);
        o_rsp_valid = (state_q == RESP);
    end

    assign o_stall = i_req & ~o_rsp_valid;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state_q == IDLE && i_req) begin
            cnt_q    <= WS;
            we_q     <= i_we;
            funct3_q <= i_funct3;
            addr_q   <= i_addr[AW+1:0];
            wdata_q  <= i_wdata;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // With zero wait states the commit edge is also the accept edge, so the
    // request is taken straight from the inputs instead of the capture regs.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = i_we;
            acc_f3    = i_funct3;
            acc_addr  = i_addr[AW+1:0];
            acc_wdata = i_wdata;
        end else begin
            acc_we    = we_q;
            acc_f3    = funct3_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign commit  = (state_d == RESP) && (state_q != RESP) && !i_arst;
    assign acc_idx = acc_addr[AW+1:2];
    assign rword   = mem[acc_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_w;
`endif

    dmem_lane_align #(.N(N)) u_align (
        .we        (acc_we),
        .funct3    (acc_f3),
        .addr_lo   (acc_addr[1:0]),
        .wdata     (acc_wdata),
        .rword     (rword),
        .rdata     (rdata_ext),
        .wbe       (wbe),
        .wdata_rep (wdata_rep)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .misaligned(mis_w)
`endif
    );

    // The array is deliberately not reset; writes only happen on commit.
    always_ff @(posedge i_clk) begin
        if (commit && acc_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) mem[acc_idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)                 o_rdata <= '0;
        else if (commit && !acc_we) o_rdata <= rdata_ext;
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) o_misaligned <= 1'b0;
        else        o_misaligned <= commit && mis_w;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req1, we1, ready1, stall1, rsp1;
    logic [2:0]  f31;
    logic [31:0] addr1, wdata1, rdata1;
    logic        req0, we0, ready0, stall0, rsp0;
    logic [2:0]  f30;
    logic [31:0] addr0, wdata0, rdata0;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        mis1, mis0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m1 [1024];
    logic [31:0] m0 [1024];

    dmem_responder #(.N(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .i_clk(clk), .i_arst(rst), .i_req(req1), .i_we(we1), .i_funct3(f31),
        .i_addr(addr1), .i_wdata(wdata1), .o_ready(ready1), .o_stall(stall1),
        .o_rsp_valid(rsp1), .o_rdata(rdata1)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .o_misaligned(mis1)
`endif
    );

    dmem_responder #(.N(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_arst(rst), .i_req(req0), .i_we(we0), .i_funct3(f30),
        .i_addr(addr0), .i_wdata(wdata0), .o_ready(ready0), .o_stall(stall0),
        .o_rsp_valid(rsp0), .o_rdata(rdata0)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .o_misaligned(mis0)
`endif
    );

    function automatic logic m_mis(input logic we, input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return ((f3 == 3'd1 || (!we && f3 == 3'd5)) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] b, h;
        if (m_mis(1'b0, f3, a)) return 32'h0;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b ^ 32'h80) - 32'h80;
            3'd1:    return (h ^ 32'h8000) - 32'h8000;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] d);
        if (m_mis(1'b1, f3, a)) return old;
        case (f3)
            3'd0:    return (old & ~(32'hFF << (8 * a[1:0]))) | ((d & 32'hFF) << (8 * a[1:0]));
            3'd1:    return (old & ~(32'hFFFF << (16 * a[1]))) | ((d & 32'hFFFF) << (16 * a[1]));
            3'd2:    return d;
            default: return old;
        endcase
    endfunction

    // One request on dut1: checks accept, response latency and stall window.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic mis);
        int   lat;
        int   stall_cyc;
        logic stall_resp;
        @(negedge clk);
        req1 = 1'b1; we1 = we; f31 = f3; addr1 = a; wdata1 = d;
        #1;
        n_tests++;
        if (ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: o_ready=%b required 1 (addr %h)", ready1, a);
        end
        stall_cyc = (stall1 === 1'b1) ? 1 : 0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp1 === 1'b1) break;
            if (stall1 === 1'b1) stall_cyc++;
        end
        stall_resp = stall1;
        rd = rdata1;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = mis1;
`else
        mis = 1'b0;
`endif
        n_tests++;
        if (rsp1 !== 1'b1 || lat != 2) begin
            n_fail++;
            $display("FAIL rsp_latency: got %0d cycles (rsp=%b) required 2 (addr %h)", lat, rsp1, a);
        end
        n_tests++;
        if (stall_cyc != 2 || stall_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_window: %0d stall cycles, stall in RESP=%b, required 2 and 0", stall_cyc, stall_resp);
        end
        req1 = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req1 = 0; we1 = 0; f31 = 0; addr1 = 0; wdata1 = 0;
        req0 = 0; we0 = 0; f30 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ready1, rsp1, stall1} !== 3'b100 || rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut1: ready/rsp/stall=%b rdata=%h required 100 00000000", {ready1, rsp1, stall1}, rdata1);
        end
        n_tests++;
        if ({ready0, rsp0, stall0} !== 3'b100 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: ready/rsp/stall=%b rdata=%h required 100 00000000", {ready0, rsp0, stall0}, rdata0);
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("reset_misaligned", {31'd0, mis1}, 32'h0);
`endif
        rst = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic mis;
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, mis);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, mis);
        chk("lw_0x10", rd, 32'hDEADBEEF);
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic mis;
        do_req(1'b1, 3'd2, 32'h20, 32'h0, rd, mis);
        do_req(1'b1, 3'd0, 32'h21, 32'h80, rd, mis);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, mis);
        chk("lw_after_sb", rd, 32'h00008000);
        do_req(1'b0, 3'd0, 32'h21, 32'h0, rd, mis);
        chk("lb_0x21", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h21, 32'h0, rd, mis);
        chk("lbu_0x21", rd, 32'h00000080);
    endtask

    task automatic test_half;
        logic [31:0] rd; logic mis;
        do_req(1'b1, 3'd2, 32'h30, 32'h0, rd, mis);
        do_req(1'b1, 3'd1, 32'h32, 32'h8001, rd, mis);
        do_req(1'b0, 3'd1, 32'h32, 32'h0, rd, mis);
        chk("lh_0x32", rd, 32'hFFFF8001);
        do_req(1'b0, 3'd5, 32'h32, 32'h0, rd, mis);
        chk("lhu_0x32", rd, 32'h00008001);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, rd, mis);
        chk("lw_after_sh", rd, 32'h80010000);
    endtask

    task automatic test_unsupported;
        logic [31:0] rd; logic mis;
        do_req(1'b1, 3'd2, 32'h50, 32'h12345678, rd, mis);
        chk("store_keeps_rdata", rd, 32'h80010000);
        do_req(1'b1, 3'd3, 32'h50, 32'hFFFFFFFF, rd, mis);
        do_req(1'b0, 3'd2, 32'h50, 32'h0, rd, mis);
        chk("bad_store_no_write", rd, 32'h12345678);
        do_req(1'b0, 3'd6, 32'h50, 32'h0, rd, mis);
        chk("bad_load_zero", rd, 32'h0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic mis;
        do_req(1'b1, 3'd2, 32'h40, 32'h11111111, rd, mis);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, rd, mis);
        chk("lw_before_abort", rd, 32'h11111111);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; f31 = 3'd2; addr1 = 32'h40; wdata1 = 32'h22222222;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({ready1, rsp1} !== 2'b10 || rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ready/rsp=%b rdata=%h required 10 00000000", {ready1, rsp1}, rdata1);
        end
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 3'd2, 32'h40, 32'h0, rd, mis);
        chk("aborted_store_dropped", rd, 32'h11111111);
        do_req(1'b0, 3'd2, 32'h7000_1040, 32'h0, rd, mis);
        chk("addr_wrap", rd, 32'h11111111);
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic mis;
        do_req(1'b0, 3'd2, 32'h13, 32'h0, rd, mis);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw_0x13_mis", {31'd0, mis}, 32'h1);
        chk("lw_0x13_data", rd, 32'h0);
`else
        chk("lw_0x13_data", rd, 32'hDEADBEEF);
`endif
        do_req(1'b1, 3'd1, 32'h31, 32'h7777, rd, mis);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, rd, mis);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("sh_0x31_blocked", rd, 32'h80010000);
`else
        chk("sh_0x31_aligned", rd, 32'h80017777);
`endif
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d, exp, last_rd;
        logic        mis, we;
        logic [2:0]  f3;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            m1[i] = d;
            do_req(1'b1, 3'd2, 32'(i * 4), d, rd, mis);
        end
        do_req(1'b0, 3'd2, 32'h0, 32'h0, rd, mis);
        chk("rand_first_lw", rd, m1[0]);
        last_rd = m1[0];
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = (32'($urandom_range(0, 15)) << 12) | 32'($urandom_range(0, 255));
            d  = $urandom;
            do_req(we, f3, a, d, rd, mis);
            if (we) begin
                m1[a[11:2]] = m_store(m1[a[11:2]], f3, a, d);
                exp = last_rd;
            end else begin
                exp = m_load(m1[a[11:2]], f3, a);
                last_rd = exp;
            end
            n_tests++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL rand_op%0d we=%b f3=%0d addr=%h: rdata %h required %h", i, we, f3, a, rd, exp);
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            chk("rand_mis", {31'd0, mis}, {31'd0, m_mis(we, f3, a)});
`endif
        end
    endtask

    // Zero wait states, i_req held high throughout: one request every two cycles.
    task automatic test_back_to_back;
        logic [31:0] a, d, exp;
        logic        we;
        logic [2:0]  f3;
        @(negedge clk);
        for (int i = 0; i < 56; i++) begin
            if (i < 16) begin
                we = 1'b1; f3 = 3'd2; a = 32'(i * 4); d = $urandom;
            end else begin
                we = 1'($urandom_range(0, 1));
                f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                a  = (32'($urandom_range(0, 15)) << 12) | 32'($urandom_range(0, 63));
                d  = $urandom;
            end
            req0 = 1'b1; we0 = we; f30 = f3; addr0 = a; wdata0 = d;
            #1;
            n_tests++;
            if ({ready0, rsp0, stall0} !== 3'b101) begin
                n_fail++;
                $display("FAIL b2b_accept%0d: ready/rsp/stall=%b required 101", i, {ready0, rsp0, stall0});
            end
            @(negedge clk);
            n_tests++;
            if ({ready0, rsp0, stall0} !== 3'b010) begin
                n_fail++;
                $display("FAIL b2b_resp%0d: ready/rsp/stall=%b required 010", i, {ready0, rsp0, stall0});
            end
            if (we) begin
                m0[a[11:2]] = m_store(m0[a[11:2]], f3, a, d);
            end else begin
                exp = m_load(m0[a[11:2]], f3, a);
                n_tests++;
                if (rdata0 !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_load%0d f3=%0d addr=%h: rdata %h required %h", i, f3, a, rdata0, exp);
                end
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            chk("b2b_mis", {31'd0, mis0}, {31'd0, m_mis(we, f3, a)});
`endif
            @(negedge clk);
        end
        req0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_unsupported();
        test_reset_mid();
        test_misalign();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
